// File: rtl/control_unit.sv
// Hardwired Moore control unit: fetch T0-T2, execute T3-T7, HALT.
// Define CU_MEM_WAIT_EN to stretch memory states until mem_done, with a WAIT_MAX timeout.
module control_unit #(
    parameter int WAIT_MAX = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IR,
    input  logic        mem_done,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Cout,
    output logic        Read,
    output logic        Write,
    output logic [3:0]  alu_op,
    output logic        run,
    output logic        mem_err,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        T0   = 4'd0,
        T1   = 4'd1,
        T2   = 4'd2,
        T3   = 4'd3,
        T4   = 4'd4,
        T5   = 4'd5,
        T6   = 4'd6,
        T7   = 4'd7,
        HALT = 4'd8
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t     cur_state;
    state_t     next_state;
    logic [4:0] op_reg;
    logic       in_mem_state;
    logic       mem_hold;
    logic       mem_timeout;
    logic       is_alu;
    logic       is_ld;
    logic       is_st;
    logic       uses_base;
    logic       unused_ir;

    assign unused_ir = ^IR[26:0];
    assign state     = cur_state;

    assign is_alu    = (op_reg == OP_ADD) || (op_reg == OP_SUB) ||
                       (op_reg == OP_AND) || (op_reg == OP_OR);
    assign is_ld     = (op_reg == OP_LD);
    assign is_st     = (op_reg == OP_ST);
    assign uses_base = is_ld || is_st || (op_reg == OP_LDI);

    assign in_mem_state = (cur_state == T1) ||
                          ((cur_state == T6) && is_ld) ||
                          ((cur_state == T7) && is_st);

`ifdef CU_MEM_WAIT_EN
    localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    logic [CW-1:0] wait_cnt;
    logic          mem_err_q;

    assign mem_hold    = in_mem_state && !mem_done;
    assign mem_timeout = mem_hold && (wait_cnt == CW'(WAIT_MAX - 1));
    assign mem_err     = mem_err_q;

    // Counts consecutive cycles spent waiting on memory; cleared whenever the wait ends.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
        end else begin
            if (mem_hold && !mem_timeout)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (mem_timeout)
                mem_err_q <= 1'b1;
        end
    end
`else
    logic unused_mem;

    assign unused_mem  = mem_done ^ (WAIT_MAX == 0);
    assign mem_hold    = 1'b0;
    assign mem_timeout = 1'b0;
    assign mem_err     = 1'b0;
`endif

    // The opcode is captured as IR is loaded so later steps do not depend on the live IR.
    always_ff @(posedge clock) begin
        if (reset) begin
            cur_state <= T0;
            op_reg    <= 5'b00000;
        end else begin
            cur_state <= next_state;
            if (cur_state == T2)
                op_reg <= IR[31:27];
        end
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            T0: next_state = T1;
            T1: next_state = mem_hold ? T1 : T2;
            T2: begin
                case (IR[31:27])
                    OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB,
                    OP_AND, OP_OR, OP_ADDI, OP_JR: next_state = T3;
                    OP_HALT:                       next_state = HALT;
                    default:                       next_state = T0;
                endcase
            end
            T3:      next_state = (op_reg == OP_JR) ? T0 : T4;
            T4:      next_state = T5;
            T5:      next_state = (is_ld || is_st) ? T6 : T0;
            T6:      next_state = mem_hold ? T6 : T7;
            T7:      next_state = mem_hold ? T7 : T0;
            HALT:    next_state = HALT;
            default: next_state = T0;
        endcase
        if (mem_timeout)
            next_state = HALT;
    end

    always_comb begin
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        Rin     = 1'b0;
        Rout    = 1'b0;
        BAout   = 1'b0;
        PCout   = 1'b0;
        PCin    = 1'b0;
        IncPC   = 1'b0;
        MARin   = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
        Cout    = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        alu_op  = 4'b0000;
        run     = (cur_state != HALT);
        case (cur_state)
            T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                if (op_reg == OP_JR) begin
                    Gra  = 1'b1;
                    Rout = 1'b1;
                    PCin = 1'b1;
                end else begin
                    Grb   = 1'b1;
                    Yin   = 1'b1;
                    BAout = uses_base;
                    Rout  = !uses_base;
                end
            end
            T4: begin
                Zin = 1'b1;
                if (is_alu) begin
                    Grc  = 1'b1;
                    Rout = 1'b1;
                    case (op_reg)
                        OP_SUB:  alu_op = 4'b0001;
                        OP_AND:  alu_op = 4'b0010;
                        OP_OR:   alu_op = 4'b0011;
                        default: alu_op = 4'b0000;
                    endcase
                end else begin
                    Cout = 1'b1;
                end
            end
            T5: begin
                Zlowout = 1'b1;
                if (is_ld || is_st) begin
                    MARin = 1'b1;
                end else begin
                    Gra = 1'b1;
                    Rin = 1'b1;
                end
            end
            T6: begin
                MDRin = 1'b1;
                if (is_ld) begin
                    Read = 1'b1;
                end else begin
                    Gra  = 1'b1;
                    Rout = 1'b1;
                end
            end
            T7: begin
                if (is_ld) begin
                    MDRout = 1'b1;
                    Gra    = 1'b1;
                    Rin    = 1'b1;
                end else begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: an instruction-level microstep table predicts every cycle.
// Memory-wait scenarios are exercised only when CU_MEM_WAIT_EN is defined.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] IR;
    logic        mem_done;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout;
    logic        Read, Write;
    logic [3:0]  alu_op;
    logic        run;
    logic        mem_err;
    logic [3:0]  state;
    logic [18:0] obs;

    int checks = 0;
    int errors = 0;

    localparam logic [18:0] M_GRA     = 19'h00001;
    localparam logic [18:0] M_GRB     = 19'h00002;
    localparam logic [18:0] M_GRC     = 19'h00004;
    localparam logic [18:0] M_RIN     = 19'h00008;
    localparam logic [18:0] M_ROUT    = 19'h00010;
    localparam logic [18:0] M_BAOUT   = 19'h00020;
    localparam logic [18:0] M_PCOUT   = 19'h00040;
    localparam logic [18:0] M_PCIN    = 19'h00080;
    localparam logic [18:0] M_INCPC   = 19'h00100;
    localparam logic [18:0] M_MARIN   = 19'h00200;
    localparam logic [18:0] M_MDRIN   = 19'h00400;
    localparam logic [18:0] M_MDROUT  = 19'h00800;
    localparam logic [18:0] M_IRIN    = 19'h01000;
    localparam logic [18:0] M_YIN     = 19'h02000;
    localparam logic [18:0] M_ZIN     = 19'h04000;
    localparam logic [18:0] M_ZLOWOUT = 19'h08000;
    localparam logic [18:0] M_COUT    = 19'h10000;
    localparam logic [18:0] M_READ    = 19'h20000;
    localparam logic [18:0] M_WRITE   = 19'h40000;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef struct {
        logic [3:0]  st;
        logic [18:0] strb;
        logic [3:0]  alu;
        bit          mem;
    } step_t;

    step_t prog[$];

    always #5 clock = ~clock;

    assign obs = {Write, Read, Cout, Zlowout, Zin, Yin, IRin, MDRout, MDRin, MARin,
                  IncPC, PCin, PCout, BAout, Rout, Rin, Grc, Grb, Gra};

    control_unit #(.WAIT_MAX(15)) dut (
        .clock(clock), .reset(reset), .IR(IR), .mem_done(mem_done),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
        .Cout(Cout), .Read(Read), .Write(Write), .alu_op(alu_op), .run(run),
        .mem_err(mem_err), .state(state)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkStep(input string tag, input logic [3:0] st, input logic [18:0] strb,
                             input logic [3:0] alu, input logic err);
        checkOutput($sformatf("%s_state", tag), 32'(state), 32'(st));
        checkOutput($sformatf("%s_strobes", tag), 32'(obs), 32'(strb));
        checkOutput($sformatf("%s_alu", tag), 32'(alu_op), 32'(alu));
        checkOutput($sformatf("%s_run", tag), 32'(run), 32'(st != 4'd8));
        checkOutput($sformatf("%s_memerr", tag), 32'(mem_err), 32'(err));
    endtask

    function automatic step_t mk(input int st, input logic [18:0] strb, input int alu, input bit mem);
        step_t s;
        s.st   = 4'(st);
        s.strb = strb;
        s.alu  = 4'(alu);
        s.mem  = mem;
        return s;
    endfunction

    // Microstep table for one instruction, written straight from the instruction descriptions.
    task automatic buildProgram(input logic [4:0] op);
        prog.delete();
        prog.push_back(mk(0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 0, 0));
        prog.push_back(mk(1, M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 0, 1));
        prog.push_back(mk(2, M_MDROUT | M_IRIN, 0, 0));
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                prog.push_back(mk(3, M_GRB | M_ROUT | M_YIN, 0, 0));
                prog.push_back(mk(4, M_GRC | M_ROUT | M_ZIN, int'(op) - 3, 0));
                prog.push_back(mk(5, M_ZLOWOUT | M_GRA | M_RIN, 0, 0));
            end
            OP_ADDI, OP_LDI: begin
                prog.push_back(mk(3, M_GRB | M_YIN | ((op == OP_LDI) ? M_BAOUT : M_ROUT), 0, 0));
                prog.push_back(mk(4, M_COUT | M_ZIN, 0, 0));
                prog.push_back(mk(5, M_ZLOWOUT | M_GRA | M_RIN, 0, 0));
            end
            OP_LD, OP_ST: begin
                prog.push_back(mk(3, M_GRB | M_BAOUT | M_YIN, 0, 0));
                prog.push_back(mk(4, M_COUT | M_ZIN, 0, 0));
                prog.push_back(mk(5, M_ZLOWOUT | M_MARIN, 0, 0));
                if (op == OP_LD) begin
                    prog.push_back(mk(6, M_READ | M_MDRIN, 0, 1));
                    prog.push_back(mk(7, M_MDROUT | M_GRA | M_RIN, 0, 0));
                end else begin
                    prog.push_back(mk(6, M_GRA | M_ROUT | M_MDRIN, 0, 0));
                    prog.push_back(mk(7, M_WRITE, 0, 1));
                end
            end
            OP_JR:   prog.push_back(mk(3, M_GRA | M_ROUT | M_PCIN, 0, 0));
            OP_HALT: prog.push_back(mk(8, 19'h0, 0, 0));
            default: ;
        endcase
    endtask

    // Runs one instruction from T0 (at a negedge); limit<0 runs all steps, force_hold<0 picks random waits.
    task automatic applyStimulus(input string name, input logic [4:0] op, input int limit, input int force_hold);
        int hold;
        buildProgram(op);
        IR = {op, 27'($urandom)};
        for (int i = 0; i < prog.size(); i++) begin
            if (limit >= 0 && i >= limit) break;
            hold = 0;
`ifdef CU_MEM_WAIT_EN
            if (prog[i].mem) hold = (force_hold >= 0) ? force_hold : int'($urandom_range(0, 3));
`endif
            for (int c = 0; c <= hold; c++) begin
                checkStep($sformatf("%s_T%0d_c%0d", name, prog[i].st, c),
                          prog[i].st, prog[i].strb, prog[i].alu, 1'b0);
`ifdef CU_MEM_WAIT_EN
                if (prog[i].mem) mem_done = (c == hold);
                else             mem_done = 1'($urandom_range(0, 1));
`else
                mem_done = 1'($urandom_range(0, 1));
`endif
                if (prog[i].st >= 4'd3) IR = 32'($urandom);
                @(posedge clock);
                @(negedge clock);
            end
        end
    endtask

    task automatic doReset();
        reset    = 1'b1;
        mem_done = 1'b0;
        @(posedge clock);
        @(negedge clock);
    endtask

    logic [4:0] ops[11] = '{OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND,
                            OP_OR, OP_ADDI, OP_JR, OP_NOP, 5'b11111};

    initial begin
        logic [4:0] op;
        IR = 32'h0;
        doReset();
        checkStep("reset", 4'd0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 4'd0, 1'b0);
        reset = 1'b0;

        applyStimulus("add", OP_ADD, -1, -1);
        applyStimulus("undef", 5'b11111, -1, -1);
        applyStimulus("jr", OP_JR, -1, -1);
        applyStimulus("nop", OP_NOP, -1, -1);
        applyStimulus("st", OP_ST, -1, -1);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) op = 5'($urandom);
            else                           op = ops[$urandom_range(0, 10)];
            if (op == OP_HALT) op = OP_NOP;
            applyStimulus($sformatf("rnd%0d", n), op, -1, -1);
        end

`ifdef CU_MEM_WAIT_EN
        applyStimulus("ld_wait3", OP_LD, -1, 3);

        // Memory never answers during fetch: 15 waiting cycles then HALT with mem_err.
        doReset();
        reset = 1'b0;
        IR = 32'($urandom);
        checkStep("to_T0", 4'd0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 4'd0, 1'b0);
        @(posedge clock);
        @(negedge clock);
        for (int c = 0; c < 15; c++) begin
            checkStep($sformatf("to_T1_c%0d", c), 4'd1, M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 4'd0, 1'b0);
            mem_done = 1'b0;
            @(posedge clock);
            @(negedge clock);
        end
        checkStep("to_halt", 4'd8, 19'h0, 4'd0, 1'b1);
        doReset();
        checkStep("to_reset", 4'd0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 4'd0, 1'b0);
        reset = 1'b0;
`endif

        applyStimulus("halt", OP_HALT, -1, -1);
        for (int c = 0; c < 20; c++) begin
            IR       = 32'($urandom);
            mem_done = 1'($urandom_range(0, 1));
            checkStep($sformatf("halt_hold%0d", c), 4'd8, 19'h0, 4'd0, 1'b0);
            @(posedge clock);
            @(negedge clock);
        end
        doReset();
        checkStep("halt_reset", 4'd0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 4'd0, 1'b0);
        reset = 1'b0;

        // Reset lands while st sits in T6, before its write cycle.
        applyStimulus("st_rst", OP_ST, 6, 0);
        checkOutput("st_rst_in_T6", 32'(state), 32'd6);
        doReset();
        checkStep("st_rst_after", 4'd0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 4'd0, 1'b0);
        reset = 1'b0;
        applyStimulus("post_rst_add", OP_OR, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
